// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, S-box/byte widths and the
// per-byte cycle cost of the PRGA engine.
package rc4_pkg;

   localparam int unsigned SBOX_AW  = 8;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned PRGA_CPB = 6;

   typedef enum logic [3:0] {
      IDLE,
      REQ_LEN,
      GET_LEN,
      REQ_I,
      GET_I,
      GET_J,
      WR_J,
      REQ_PAD,
      GET_PAD
   } prga_state_t;

endpackage

// File: rtl/rc4_prga.sv
// RC4 PRGA + decrypt: walks the length-prefixed ciphertext in ct_mem, permutes
// S in place through s_mem's single port and writes plaintext to pt_mem.
module rc4_prga
   import rc4_pkg::*;
#(
   parameter int unsigned MSG_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               rdy,
   output logic [SBOX_AW-1:0] s_addr,
   input  logic [BYTE_W-1:0]  s_rddata,
   output logic [BYTE_W-1:0]  s_wrdata,
   output logic               s_wren,
   output logic [MSG_AW-1:0]  ct_addr,
   input  logic [BYTE_W-1:0]  ct_rddata,
   output logic [MSG_AW-1:0]  pt_addr,
   output logic [BYTE_W-1:0]  pt_wrdata,
   output logic               pt_wren
);

   prga_state_t         state;
   logic [SBOX_AW-1:0]  i;
   logic [SBOX_AW-1:0]  j;
   logic [BYTE_W-1:0]   k;
   logic [BYTE_W-1:0]   len;
   logic [BYTE_W-1:0]   si;
   logic [BYTE_W-1:0]   sj;
   logic [SBOX_AW-1:0]  j_next;
   logic                s_wr;
   logic                pt_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         len   <= '0;
         si    <= '0;
         sj    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) state <= REQ_LEN;
            end
            REQ_LEN: state <= GET_LEN;
            GET_LEN: begin
               len   <= ct_rddata;
               i     <= 8'd1;
               j     <= '0;
               k     <= 8'd1;
               state <= (ct_rddata == '0) ? IDLE : REQ_I;
            end
            REQ_I: state <= GET_I;
            GET_I: begin
               si    <= s_rddata;
               j     <= j_next;
               state <= GET_J;
            end
            GET_J: begin
               sj    <= s_rddata;
               state <= WR_J;
            end
            WR_J:    state <= REQ_PAD;
            REQ_PAD: state <= GET_PAD;
            GET_PAD: begin
               if (k == len) begin
                  state <= IDLE;
               end else begin
                  k     <= k + 8'd1;
                  i     <= i + 8'd1;
                  state <= REQ_I;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ct_addr stays on k from REQ_I to GET_PAD so ct_rddata lines up with the pad byte
   always_comb begin
      rdy       = 1'b0;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wr      = 1'b0;
      ct_addr   = '0;
      pt_addr   = '0;
      pt_wrdata = '0;
      pt_wr     = 1'b0;
      j_next    = j + s_rddata;
      case (state)
         IDLE: rdy = 1'b1;
         REQ_LEN: ct_addr = '0;
         GET_LEN: begin
            pt_addr   = '0;
            pt_wrdata = ct_rddata;
            pt_wr     = 1'b1;
         end
         REQ_I: begin
            s_addr  = i;
            ct_addr = MSG_AW'(k);
         end
         GET_I: begin
            s_addr  = j_next;
            ct_addr = MSG_AW'(k);
         end
         GET_J: begin
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wr     = 1'b1;
            ct_addr  = MSG_AW'(k);
         end
         WR_J: begin
            s_addr   = j;
            s_wrdata = si;
            s_wr     = 1'b1;
            ct_addr  = MSG_AW'(k);
         end
         REQ_PAD: begin
            s_addr  = si + sj;
            ct_addr = MSG_AW'(k);
         end
         GET_PAD: begin
            ct_addr   = MSG_AW'(k);
            pt_addr   = MSG_AW'(k);
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wr     = 1'b1;
         end
         default: ;
      endcase
   end

   // reset must never let a half-finished swap or plaintext byte reach memory
   assign s_wren  = s_wr  & ~rst;
   assign pt_wren = pt_wr & ~rst;

endmodule
